// File: rtl/dom_rand_source.sv
// rtl/dom_rand_source.sv - seeded 64-bit LFSR source of fresh L-bit masks for a DOM gadget
module dom_rand_source #(
  parameter int D               = 2,
  parameter int L               = ((D + 1) * D) / 2,
  parameter int WARMUP          = 16,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_valid,
  output logic         seed_ready,
  input  logic [63:0]  seed,
  output logic         rand_valid,
  input  logic         rand_ready,
  output logic [L-1:0] rand_data,
  output logic         reseed_req,
  output logic         busy
);

  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int CW = $clog2(RESEED_INTERVAL + 1);
  localparam logic [WW-1:0] W_LAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CW-1:0] C_MAX  = CW'(RESEED_INTERVAL);
  localparam logic [CW-1:0] C_PRE  = CW'(RESEED_INTERVAL - 1);

  typedef enum logic [1:0] {UNSEEDED, LOAD, WARM, RUN} state_t;

  state_t        state_q;
  logic [63:0]   s_q;
  logic [63:0]   seed_q;
  logic [WW-1:0] wcnt_q;
  logic [CW-1:0] ccnt_q;
  logic          rand_valid_q;
  logic          seed_ready_q;
  logic          reseed_req_q;
  logic          busy_q;

  logic [63:0]   s_d;
  logic [L-1:0]  word_d;

  // One word advance: L single LFSR steps unrolled, bit k is the output of step k.
  always_comb begin
    s_d    = s_q;
    word_d = '0;
    for (int k = 0; k < L; k++) begin
      word_d[k] = s_d[63];
      s_d       = {s_d[62:0], s_d[63] ^ s_d[62] ^ s_d[60] ^ s_d[59]};
    end
  end

  assign rand_data  = word_d;
  assign rand_valid = rand_valid_q;
  assign seed_ready = seed_ready_q;
  assign reseed_req = reseed_req_q;
  assign busy       = busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= UNSEEDED;
      s_q          <= 64'h0000_0000_0000_0001;
      seed_q       <= '0;
      wcnt_q       <= '0;
      ccnt_q       <= '0;
      rand_valid_q <= 1'b0;
      seed_ready_q <= 1'b0;
      reseed_req_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        UNSEEDED: begin
          seed_ready_q <= 1'b1;
          if (seed_valid && seed_ready_q) begin
            seed_q       <= seed;
            state_q      <= LOAD;
            seed_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        LOAD: begin
          // A zero seed would lock the LFSR, so it is replaced by 1.
          s_q          <= (seed_q == 64'h0) ? 64'h0000_0000_0000_0001 : seed_q;
          wcnt_q       <= '0;
          ccnt_q       <= '0;
          reseed_req_q <= 1'b0;
          if (WARMUP > 0) begin
            state_q <= WARM;
          end else begin
            state_q      <= RUN;
            busy_q       <= 1'b0;
            rand_valid_q <= 1'b1;
            seed_ready_q <= 1'b1;
          end
        end
        WARM: begin
          s_q    <= s_d;
          wcnt_q <= wcnt_q + 1'b1;
          if (wcnt_q == W_LAST) begin
            state_q      <= RUN;
            busy_q       <= 1'b0;
            rand_valid_q <= 1'b1;
            seed_ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (rand_valid_q && rand_ready) begin
            s_q <= s_d;
            if (ccnt_q != C_MAX) ccnt_q <= ccnt_q + 1'b1;
            if (ccnt_q >= C_PRE) reseed_req_q <= 1'b1;
          end
          // A seed offer takes priority; S is overwritten in LOAD anyway.
          if (seed_valid && seed_ready_q) begin
            seed_q       <= seed;
            state_q      <= LOAD;
            rand_valid_q <= 1'b0;
            seed_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        default: state_q <= UNSEEDED;
      endcase
    end
  end

endmodule

// File: tb/tb_dom_rand_source.sv
// tb/tb_dom_rand_source.sv - bench for dom_rand_source: stream model plus directed vectors
module tb_dom_rand_source;

  localparam int RI = 4;
  localparam int W0 = 0;
  localparam int W1 = 16;

  logic             clk;
  logic             rst;
  logic [1:0]       sv, rr, rv, sr, bz, rq;
  logic [1:0][63:0] sd;
  logic [1:0][2:0]  rd;

  int checks;
  int errors;

  dom_rand_source #(.D(2), .WARMUP(W0), .RESEED_INTERVAL(RI)) dut0 (
    .clk(clk), .rst(rst), .seed_valid(sv[0]), .seed_ready(sr[0]), .seed(sd[0]),
    .rand_valid(rv[0]), .rand_ready(rr[0]), .rand_data(rd[0]), .reseed_req(rq[0]), .busy(bz[0])
  );

  dom_rand_source #(.D(2), .WARMUP(W1), .RESEED_INTERVAL(RI)) dut1 (
    .clk(clk), .rst(rst), .seed_valid(sv[1]), .seed_ready(sr[1]), .seed(sd[1]),
    .rand_valid(rv[1]), .rand_ready(rr[1]), .rand_data(rd[1]), .reseed_req(rq[1]), .busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: the mask stream is the LFSR output bit sequence cut into 3-bit words.
  function automatic logic [63:0] adv(input logic [63:0] s);
    logic [63:0] t = s;
    for (int k = 0; k < 3; k++) t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
    return t;
  endfunction

  function automatic logic [2:0] word(input logic [63:0] s);
    logic [63:0] t = s;
    logic [2:0]  w = '0;
    for (int k = 0; k < 3; k++) begin
      w[k] = t[63];
      t    = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
    end
    return w;
  endfunction

  logic [63:0] m_S[2];
  logic [63:0] m_seedcap[2];
  logic        m_seeded[2], m_load[2], m_req[2], m_sr_ok[2];
  int          m_warm[2], m_cons[2];

  function automatic int warm_of(input int i);
    return (i == 0) ? W0 : W1;
  endfunction
  function automatic logic e_valid(input int i);
    return m_seeded[i] && !m_load[i] && (m_warm[i] == 0);
  endfunction
  function automatic logic e_sready(input int i);
    return m_sr_ok[i] && !m_load[i] && (m_warm[i] == 0);
  endfunction
  function automatic logic e_busy(input int i);
    return m_load[i] || (m_warm[i] > 0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_S[i] <= 64'h1; m_seedcap[i] <= '0; m_seeded[i] <= 1'b0; m_load[i] <= 1'b0;
        m_req[i] <= 1'b0; m_sr_ok[i] <= 1'b0; m_warm[i] <= 0; m_cons[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_sr_ok[i] <= 1'b1;
        if (m_load[i]) begin
          m_S[i]      <= (m_seedcap[i] == 64'h0) ? 64'h1 : m_seedcap[i];
          m_load[i]   <= 1'b0;
          m_warm[i]   <= warm_of(i);
          m_cons[i]   <= 0;
          m_req[i]    <= 1'b0;
          m_seeded[i] <= 1'b1;
        end else if (m_warm[i] > 0) begin
          m_S[i]    <= adv(m_S[i]);
          m_warm[i] <= m_warm[i] - 1;
        end else if (e_sready(i) && sv[i]) begin
          m_load[i]    <= 1'b1;
          m_seedcap[i] <= sd[i];
        end else if (e_valid(i) && rr[i]) begin
          m_S[i] <= adv(m_S[i]);
          if (m_cons[i] + 1 >= RI) begin
            m_cons[i] <= RI;
            m_req[i]  <= 1'b1;
          end else begin
            m_cons[i] <= m_cons[i] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rand_valid%0d", i), 64'(rv[i]), 64'(e_valid(i)));
        chk($sformatf("seed_ready%0d", i), 64'(sr[i]), 64'(e_sready(i)));
        chk($sformatf("busy%0d", i), 64'(bz[i]), 64'(e_busy(i)));
        chk($sformatf("reseed_req%0d", i), 64'(rq[i]), 64'(m_req[i]));
        if (e_valid(i)) chk($sformatf("rand_data%0d", i), 64'(rd[i]), 64'(word(m_S[i])));
      end
    end
  end

  initial begin
    logic [2:0]  held;
    logic [63:0] s16;
    int          n;
    checks = 0;
    errors = 0;

    chk("model_word_e000", 64'(word(64'hE000_0000_0000_0000)), 64'h7);
    chk("model_word2_e000", 64'(word(adv(64'hE000_0000_0000_0000))), 64'h0);
    chk("model_word_a000", 64'(word(64'hA000_0000_0000_0000)), 64'h5);

    rst = 1'b0;
    sv  = 2'($urandom);
    rr  = 2'($urandom);
    sd[0] = {$urandom, $urandom};
    sd[1] = {$urandom, $urandom};
    #12;
    chk("rst_valid", 64'(rv), 64'h0);
    chk("rst_sready", 64'(sr), 64'h0);
    chk("rst_busy", 64'(bz), 64'h0);
    chk("rst_req", 64'(rq), 64'h0);
    @(negedge clk);
    sv = 2'b00; rr = 2'b00; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("unseeded_sready", 64'(sr), 64'h3);
    chk("unseeded_valid", 64'(rv), 64'h0);

    sd[0] = 64'hE000_0000_0000_0000; sv[0] = 1'b1;
    @(negedge clk);
    sv[0] = 1'b0;
    chk("load_valid", 64'(rv[0]), 64'h0);
    chk("load_busy", 64'(bz[0]), 64'h1);
    @(negedge clk);
    chk("first_valid", 64'(rv[0]), 64'h1);
    chk("first_word", 64'(rd[0]), 64'h7);
    rr[0] = 1'b1;
    @(negedge clk);
    chk("second_word", 64'(rd[0]), 64'h0);
    repeat (999) @(negedge clk);
    rr[0] = 1'b0;
    chk("req_after_1000", 64'(rq[0]), 64'h1);

    @(negedge clk);
    held = rd[0];
    chk("held_vs_model", 64'(held), 64'(word(m_S[0])));
    repeat (50) begin
      @(negedge clk);
      chk("backpressure_stable", 64'(rd[0]), 64'(held));
    end
    rr[0] = 1'b1;
    @(negedge clk);

    sd[0] = 64'hA000_0000_0000_0000; sv[0] = 1'b1; rr[0] = 1'b1;
    @(negedge clk);
    sv[0] = 1'b0; rr[0] = 1'b0;
    chk("reseed_drop_valid", 64'(rv[0]), 64'h0);
    @(negedge clk);
    chk("reseed_valid", 64'(rv[0]), 64'h1);
    chk("reseed_word", 64'(rd[0]), 64'h5);
    chk("reseed_req_clear", 64'(rq[0]), 64'h0);
    rr[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("req_after_3", 64'(rq[0]), 64'h0);
    @(negedge clk);
    chk("req_after_4", 64'(rq[0]), 64'h1);
    repeat (3) @(negedge clk);
    chk("req_sticky", 64'(rq[0]), 64'h1);
    chk("deliver_with_req", 64'(rv[0]), 64'h1);
    rr[0] = 1'b0;

    sd[1] = 64'h0; sv[1] = 1'b1;
    @(negedge clk);
    sv[1] = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (rv[1]) break;
      if (bz[1]) n++;
      @(negedge clk);
    end
    chk("zero_seed_busy_cycles", 64'(n), 64'd17);
    chk("zero_seed_valid", 64'(rv[1]), 64'h1);
    s16 = 64'h1;
    for (int k = 0; k < 16; k++) s16 = adv(s16);
    chk("zero_seed_word", 64'(rd[1]), 64'(word(s16)));
    rr[1] = 1'b1;
    repeat (20) @(negedge clk);
    rr[1] = 1'b0;

    sd[1] = 64'h5; sv[1] = 1'b1;
    @(negedge clk);
    sv[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("warmup_busy", 64'(bz[1]), 64'h1);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", 64'(rv), 64'h0);
    chk("async_sready", 64'(sr), 64'h0);
    chk("async_busy", 64'(bz), 64'h0);
    chk("async_req", 64'(rq), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_valid", 64'(rv[1]), 64'h0);
    chk("post_reset_sready", 64'(sr[1]), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
